// File: rtl/mips_pipe_ctrl.sv
// rtl/mips_pipe_ctrl.sv - fetch, IF/ID, hazard, forwarding and redirect control for a 5-stage MIPS pipe
module mips_pipe_ctrl #(
  parameter int PC_W     = 10,
  parameter int RESET_PC = 0,
  parameter int FWD_EN   = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       id_inst,
  output logic [PC_W-1:0]   id_pc,
  output logic              id_valid,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [4:0]        ex_rs,
  input  logic [4:0]        ex_rt,
  input  logic [4:0]        ex_rd_dest,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [4:0]        mem_rd_dest,
  input  logic              mem_reg_write,
  input  logic [4:0]        wb_rd_dest,
  input  logic              wb_reg_write,
  input  logic              ex_branch_taken,
  input  logic [PC_W-1:0]   ex_branch_target,
  output logic              stall,
  output logic              id_ex_bubble,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  cyc_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [PC_W-1:0]  PC_RST  = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0]  PC_ONE  = PC_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [5:0]       OP_J    = 6'b000010;

  logic [PC_W-1:0] pc;
  logic            id_jump;
  logic            hit_ex;
  logic            hit_mem;

  assign imem_addr = pc;
  assign id_jump   = id_valid && (id_inst[31:26] == OP_J);

  // Does the instruction in ID read register r (r0 never counts)?
  function automatic logic id_reads(input logic [4:0] r, input logic [31:0] inst,
                                    input logic vld, input logic urs, input logic urt);
    id_reads = vld && (r != 5'd0) &&
               ((urs && inst[25:21] == r) || (urt && inst[20:16] == r));
  endfunction

  // Saturating increment shared by all performance counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    sat_inc = (c == CNT_MAX) ? c : c + CNT_ONE;
  endfunction

  // Hazard detection: load-use only with forwarding, every RAW on EX/MEM without it.
  always_comb begin
    hit_ex  = id_reads(ex_rd_dest, id_inst, id_valid, id_uses_rs, id_uses_rt);
    hit_mem = id_reads(mem_rd_dest, id_inst, id_valid, id_uses_rs, id_uses_rt);
    if (FWD_EN != 0) begin
      stall = ex_mem_read && ex_reg_write && hit_ex;
    end else begin
      stall = (ex_reg_write && hit_ex) || (mem_reg_write && hit_mem);
    end
    id_ex_bubble = stall || ex_branch_taken;
  end

  // Forwarding selects; EX/MEM result is younger so it wins over MEM/WB.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (FWD_EN != 0) begin
      if (mem_reg_write && mem_rd_dest != 5'd0 && mem_rd_dest == ex_rs) begin
        fwd_a = 2'b10;
      end else if (wb_reg_write && wb_rd_dest != 5'd0 && wb_rd_dest == ex_rs) begin
        fwd_a = 2'b01;
      end
      if (mem_reg_write && mem_rd_dest != 5'd0 && mem_rd_dest == ex_rt) begin
        fwd_b = 2'b10;
      end else if (wb_reg_write && wb_rd_dest != 5'd0 && wb_rd_dest == ex_rt) begin
        fwd_b = 2'b01;
      end
    end
  end

  // PC and IF/ID update: branch beats stall, stall beats jump, else sequential fetch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc        <= PC_RST;
      id_inst   <= 32'd0;
      id_pc     <= '0;
      id_valid  <= 1'b0;
      cyc_cnt   <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      cyc_cnt <= sat_inc(cyc_cnt);
      if (ex_branch_taken) begin
        pc        <= ex_branch_target;
        id_inst   <= 32'd0;
        id_valid  <= 1'b0;
        flush_cnt <= sat_inc(flush_cnt);
      end else if (stall) begin
        stall_cnt <= sat_inc(stall_cnt);
      end else if (id_jump) begin
        pc        <= id_inst[PC_W-1:0];
        id_inst   <= 32'd0;
        id_valid  <= 1'b0;
        flush_cnt <= sat_inc(flush_cnt);
      end else begin
        pc       <= pc + PC_ONE;
        id_inst  <= imem_rdata;
        id_pc    <= pc;
        id_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mips_pipe_ctrl.sv
// tb/tb_mips_pipe_ctrl.sv - directed scoreboard bench for mips_pipe_ctrl
module tb_mips_pipe_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1;
  logic uses_rs, uses_rt;
  logic [4:0] ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic ex_we, ex_mr, mem_we, wb_we, br;
  logic [3:0] tg0;
  logic [9:0] tg1;

  logic [31:0] mem0 [16];
  logic [31:0] mem1 [1024];

  logic [3:0]  addr0, idpc0;
  logic [31:0] rdata0, inst0;
  logic        val0, stall0, bub0;
  logic [1:0]  fa0, fb0;
  logic [3:0]  cyc0, stc0, flc0;

  logic [9:0]  addr1, idpc1;
  logic [31:0] rdata1, inst1;
  logic        val1, stall1, bub1;
  logic [1:0]  fa1, fb1;
  logic [15:0] cyc1, stc1, flc1;

  assign rdata0 = mem0[addr0];
  assign rdata1 = mem1[addr1];

  mips_pipe_ctrl #(.PC_W(4), .RESET_PC(0), .FWD_EN(0), .CNT_W(4)) u_dut0 (
    .clk(clk), .rst(rst0), .imem_addr(addr0), .imem_rdata(rdata0),
    .id_inst(inst0), .id_pc(idpc0), .id_valid(val0),
    .id_uses_rs(uses_rs), .id_uses_rt(uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd_dest(ex_rd),
    .ex_reg_write(ex_we), .ex_mem_read(ex_mr),
    .mem_rd_dest(mem_rd), .mem_reg_write(mem_we),
    .wb_rd_dest(wb_rd), .wb_reg_write(wb_we),
    .ex_branch_taken(br), .ex_branch_target(tg0),
    .stall(stall0), .id_ex_bubble(bub0), .fwd_a(fa0), .fwd_b(fb0),
    .cyc_cnt(cyc0), .stall_cnt(stc0), .flush_cnt(flc0)
  );

  mips_pipe_ctrl #(.PC_W(10), .RESET_PC(0), .FWD_EN(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst(rst1), .imem_addr(addr1), .imem_rdata(rdata1),
    .id_inst(inst1), .id_pc(idpc1), .id_valid(val1),
    .id_uses_rs(uses_rs), .id_uses_rt(uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd_dest(ex_rd),
    .ex_reg_write(ex_we), .ex_mem_read(ex_mr),
    .mem_rd_dest(mem_rd), .mem_reg_write(mem_we),
    .wb_rd_dest(wb_rd), .wb_reg_write(wb_we),
    .ex_branch_taken(br), .ex_branch_target(tg1),
    .stall(stall1), .id_ex_bubble(bub1), .fwd_a(fa1), .fwd_b(fb1),
    .cyc_cnt(cyc1), .stall_cnt(stc1), .flush_cnt(flc1)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];
  logic [31:0] e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    uses_rs = 0; uses_rt = 0; ex_rs = 0; ex_rt = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
    ex_we = 0; ex_mr = 0; mem_we = 0; wb_we = 0; br = 0; tg0 = 0; tg1 = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem0[i] = i + 1;
    for (int i = 0; i < 1024; i++) mem1[i] = 32'h0000_0100 + i;
    clear_ctl();
    rst0 = 0; rst1 = 0;
    #2;
    step(); step();

    // straight-line fetch on 4-bit PC, reset state first
    chk("rst_addr0", addr0, 0);
    chk("rst_inst0", inst0, 0);
    chk("rst_val0", val0, 0);
    chk("rst_cyc0", cyc0, 0);
    chk("rst_stall0", stall0, 0);
    chk("rst_val1", val1, 0);
    rst0 = 1;
    for (int k = 1; k <= 20; k++) exp_q.push_back(32'((k - 1) % 16 + 1));
    for (int k = 1; k <= 20; k++) begin
      step();
      e = exp_q.pop_front();
      chk("fetch_inst", inst0, e);
      chk("fetch_idpc", idpc0, 32'((k - 1) % 16));
      chk("fetch_pc", addr0, 32'(k % 16));
      chk("fetch_valid", val0, 1);
    end
    chk("cyc_saturate", cyc0, 15);
    chk("fetch_stall_cnt", stc0, 0);
    chk("fetch_fwd_a", fa0, 0);
    chk("fetch_fwd_b", fb0, 0);

    // FWD_EN=0 RAW: two stall cycles while producer sits in EX then MEM
    rst0 = 0;
    mem0[0] = {6'd0, 5'd7, 5'd0, 5'd3, 11'h020};
    step();
    rst0 = 1;
    uses_rs = 1;
    step();
    chk("raw_inst", inst0, mem0[0]);
    ex_rd = 7; ex_we = 1;
    #1;
    chk("raw_stall_ex", stall0, 1);
    chk("raw_bubble_ex", bub0, 1);
    step();
    chk("raw_hold_pc1", addr0, 1);
    chk("raw_stc1", stc0, 1);
    ex_we = 0; mem_rd = 7; mem_we = 1; ex_rs = 7;
    #1;
    chk("raw_stall_mem", stall0, 1);
    chk("raw_nofwd", fa0, 0);
    step();
    chk("raw_stc2", stc0, 2);
    chk("raw_hold_pc2", addr0, 1);
    mem_we = 0; wb_rd = 7; wb_we = 1;
    #1;
    chk("raw_release", stall0, 0);
    step();
    chk("raw_next_pc", addr0, 2);
    chk("raw_next_inst", inst0, 2);
    clear_ctl();
    rst0 = 0;

    // load-use with forwarding
    mem1[0] = {6'd0, 5'd2, 5'd4, 5'd3, 11'h020};
    rst1 = 1;
    step();
    chk("lu_inst", inst1, mem1[0]);
    uses_rs = 1; ex_mr = 1; ex_we = 1; ex_rd = 2;
    #1;
    chk("lu_stall", stall1, 1);
    chk("lu_bubble", bub1, 1);
    step();
    chk("lu_hold_pc", addr1, 1);
    chk("lu_hold_inst", inst1, mem1[0]);
    chk("lu_stc", stc1, 1);
    ex_mr = 0; ex_we = 0; mem_rd = 2; mem_we = 1; ex_rs = 2;
    #1;
    chk("lu_stall_gone", stall1, 0);
    chk("lu_fwd_a", fa1, 2'b10);
    step();
    chk("lu_next_inst", inst1, mem1[1]);
    chk("lu_stc_once", stc1, 1);

    // forwarding priority
    mem_rd = 5; wb_rd = 5; mem_we = 1; wb_we = 1; ex_rs = 5; ex_rt = 5;
    #1;
    chk("fwd_a_exmem", fa1, 2'b10);
    chk("fwd_b_exmem", fb1, 2'b10);
    mem_we = 0;
    #1;
    chk("fwd_a_memwb", fa1, 2'b01);
    chk("fwd_b_memwb", fb1, 2'b01);
    mem_rd = 0; wb_rd = 0; mem_we = 1; ex_rs = 0; ex_rt = 0;
    #1;
    chk("fwd_a_r0", fa1, 2'b00);
    chk("fwd_b_r0", fb1, 2'b00);
    clear_ctl();

    // branch beats stall beats jump
    rst1 = 0;
    mem1[0] = {6'b000010, 5'd9, 11'd0, 10'h3C0};
    step();
    rst1 = 1;
    step();
    chk("bsj_inst", inst1, mem1[0]);
    uses_rs = 1; ex_mr = 1; ex_we = 1; ex_rd = 9; br = 1; tg1 = 10'h020;
    #1;
    chk("bsj_stall", stall1, 1);
    chk("bsj_bubble", bub1, 1);
    step();
    chk("bsj_pc", addr1, 10'h020);
    chk("bsj_valid", val1, 0);
    chk("bsj_flush", flc1, 1);
    chk("bsj_stc", stc1, 0);
    clear_ctl();

    // jump alone, then mid-stream reset
    rst1 = 0;
    mem1[0] = {6'b000010, 26'h00003C0};
    mem1[10'h3C0] = 32'hCAFE_0001;
    exp_q.push_back(32'hCAFE_0001);
    step();
    rst1 = 1;
    step();
    chk("j_valid", val1, 1);
    chk("j_pc_seq", addr1, 1);
    step();
    chk("j_pc", addr1, 10'h3C0);
    chk("j_squash", val1, 0);
    chk("j_flush", flc1, 1);
    step();
    e = exp_q.pop_front();
    chk("j_target_inst", inst1, e);
    chk("j_target_idpc", idpc1, 10'h3C0);
    chk("j_pc_next", addr1, 10'h3C1);
    chk("j_cyc", cyc1, 3);
    rst1 = 0;
    step();
    chk("mrst_pc", addr1, 0);
    chk("mrst_inst", inst1, 0);
    chk("mrst_valid", val1, 0);
    chk("mrst_idpc", idpc1, 0);
    chk("mrst_cyc", cyc1, 0);
    chk("mrst_flush", flc1, 0);
    chk("mrst_stc", stc1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_pipe_ctrl.md
Name: mips_pipe_ctrl

Overview:
- Parametrised fetch/hazard controller for the 5-stage MIPS pipeline.
- Owns the PC, the IF/ID pipeline register, load-use stall detection, EX-stage forwarding selects, branch/jump redirect with flush, and saturating performance counters.
- Sits between instruction memory, the decode/control unit and the ID/EX register of the core top level.
- Replaces the free-running PC+1 fetch, which has no stall, flush, redirect or forwarding.

Parameters:
- PC_W, 10, width of the word-addressed PC and instruction-memory index.
- RESET_PC, 0, PC value loaded on reset.
- FWD_EN, 1. 1 = forward from EX/MEM and MEM/WB. 0 = no forwarding: stall on every RAW hazard.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-low (reset when rst==0 at posedge clk).
- imem_addr  out  PC_W  equals PC; instruction memory reads combinationally.
- imem_rdata  in  32  instruction at imem_addr.
- id_inst  out  32  IF/ID instruction; 0 is a nop.
- id_pc  out  PC_W  word address of id_inst.
- id_valid  out  1  id_inst is a real instruction (not a bubble or flush).
- id_uses_rs, id_uses_rt  in  1 each  from the control unit.
- ex_rs, ex_rt, ex_rd_dest  in  5 each  ID/EX source and destination registers.
- ex_reg_write, ex_mem_read  in  1 each  ID/EX control bits.
- mem_rd_dest  in  5; mem_reg_write  in  1  EX/MEM destination and write enable.
- wb_rd_dest  in  5; wb_reg_write  in  1  MEM/WB destination and write enable.
- ex_branch_taken  in  1; ex_branch_target  in  PC_W  resolved branch from EX.
- stall  out  1  hold PC and IF/ID this cycle.
- id_ex_bubble  out  1  ID/EX register must load all-zero controls.
- fwd_a, fwd_b  out  2 each  ALU operand select. 00 = regfile, 10 = EX/MEM result, 01 = MEM/WB result.
- cyc_cnt, stall_cnt, flush_cnt  out  CNT_W each  performance counters.

Behaviour:
Reset (rst==0 at posedge):
- PC=RESET_PC, id_inst=0, id_pc=0, id_valid=0, all counters=0.
- Reset mid-operation discards all in-flight state in one cycle.
- stall, id_ex_bubble and fwd_* are combinational; they are 0 while IF/ID holds the reset nop.

Register numbering:
- Register 0 is never a hazard or forwarding source.
- The register file provides write-through, so the WB stage never causes an ID hazard.

Hazard detection (combinational):
- Let hit(r) = id_valid && r != 0 && ((id_uses_rs && inst[25:21]==r) || (id_uses_rt && inst[20:16]==r)).
- FWD_EN=1: stall = ex_mem_read && ex_reg_write && hit(ex_rd_dest) (load-use).
- FWD_EN=0: stall = (ex_reg_write && hit(ex_rd_dest)) || (mem_reg_write && hit(mem_rd_dest)). This may hold for 2 consecutive cycles.
- id_ex_bubble = stall || ex_branch_taken.

Forwarding:
- FWD_EN=1: fwd_a = 10 if mem_reg_write && mem_rd_dest!=0 && mem_rd_dest==ex_rs; else 01 if the same condition holds for wb_*; else 00. EX/MEM has priority over MEM/WB.
- fwd_b is identical using ex_rt.
- FWD_EN=0: fwd_a and fwd_b are tied to 00.

PC / IF/ID update, priority order per posedge (not in reset):
1. ex_branch_taken:
   - PC <= ex_branch_target; id_inst <= 0; id_valid <= 0.
   - Overrides any stall or jump in the same cycle.
   - flush_cnt increments.
2. stall:
   - PC and IF/ID hold.
   - stall_cnt increments.
3. Jump in ID (id_valid && id_inst[31:26]==6'b000010):
   - PC <= id_inst[PC_W-1:0].
   - IF/ID <= nop with id_valid=0 (the sequentially fetched instruction is squashed).
   - flush_cnt increments.
   - A jump held in ID by a stall takes effect only in the first cycle stall is low.
4. Otherwise:
   - PC <= PC+1, wrapping modulo 2^PC_W.
   - id_inst <= imem_rdata; id_pc <= PC; id_valid <= 1.

Counters:
- cyc_cnt increments every non-reset cycle.
- All counters saturate at 2^CNT_W-1 and never wrap.

Latency:
- Redirect (branch or jump) costs 1 fetch-slot bubble for a jump and 2 for a taken branch.
- Load-use costs 1 cycle with FWD_EN=1.

Test Plan:
1. Straight-line fetch: rst=0 for 2 cycles, then release with PC_W=4 and imem[i]=i+1.
   -> id_inst sequence is 1,2,3…; PC wraps 15->0; fwd_a=fwd_b=00; stall_cnt=0.
2. Load-use with FWD_EN=1: lw $2 in EX (ex_mem_read=1, ex_rd_dest=2), add $3,$2,$4 in ID with uses_rs=1.
   -> stall=1 and id_ex_bubble=1 for exactly 1 cycle; PC and id_inst held; stall_cnt=1.
   -> Next cycle, with mem_rd_dest=2 and ex_rs=2: fwd_a=10.
3. Forwarding priority: mem_rd_dest=5 and wb_rd_dest=5, both write enables set, ex_rs=5.
   -> fwd_a=10.
   -> Drop mem_reg_write: fwd_a=01.
   -> Set all dest registers to 0: fwd_a=00.
4. FWD_EN=0 RAW: ex_rd_dest=7 with reg_write, ID reads $7.
   -> stall for 2 cycles as the producer moves through EX then MEM; released once the producer reaches WB.
5. Branch vs stall vs jump in the same cycle: ex_branch_taken=1 with target 0x20, load-use stall active, jump in ID.
   -> PC=0x20; id_valid=0; flush_cnt+1; stall_cnt unchanged.
6. Jump 0x3C0 in ID, then mid-stream rst=0: jump alone redirects PC to 0x3C0 and squashes one slot (id_valid=0 one cycle).
   -> Asserting rst=0 afterwards returns PC=RESET_PC, id_inst=0 and all counters=0 on the next edge.
